// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit direction counters,
// trained by EX-stage resolutions, with a registered one-cycle mispredict flush.
module branch_predictor #(
    parameter int SIZE     = 32,
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    input  logic [SIZE-1:0] if_pc_i,
    output logic            pred_taken_o,
    output logic [SIZE-1:0] pred_target_o,
    input  logic            ex_valid_i,
    input  logic            ex_is_branch_i,
    input  logic [SIZE-1:0] ex_pc_i,
    input  logic            ex_taken_i,
    input  logic [SIZE-1:0] ex_target_i,
    input  logic            ex_pred_taken_i,
    input  logic [SIZE-1:0] ex_pred_target_i,
    output logic            flush_o,
    output logic [SIZE-1:0] redirect_pc_o,
    output logic [31:0]     br_cnt_o,
    output logic [31:0]     mispred_cnt_o
);
    localparam int              ENTRIES = 1 << IDX_BITS;
    localparam logic [SIZE-1:0] PC_STEP = SIZE'(4);

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [SIZE-1:0]     r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    logic                r_flush_p1;
    logic [SIZE-1:0]     r_redirect_pc_p1;
    logic [31:0]         r_br_cnt;
    logic [31:0]         r_mispred_cnt;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic                w_if_hit;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [TAG_BITS-1:0] w_ex_tag;
    logic                w_ex_hit;
    logic                w_upd;
    logic [SIZE-1:0]     w_actual_pc;
    logic [SIZE-1:0]     w_pred_pc;
    logic                w_mispred;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // IF stage: zero-latency lookup against pre-update table contents
    assign w_if_idx      = if_pc_i[IDX_BITS+1:2];
    assign w_if_tag      = if_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_if_hit      = if_valid_i & r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken_o  = w_if_hit & r_ctr[w_if_idx][1];
    assign pred_target_o = pred_taken_o ? r_target[w_if_idx] : if_pc_i + PC_STEP;

    // EX stage: resolution, training and mispredict detection
    assign w_ex_idx    = ex_pc_i[IDX_BITS+1:2];
    assign w_ex_tag    = ex_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_ex_hit    = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd       = ex_valid_i & ex_is_branch_i;
    assign w_actual_pc = ex_taken_i      ? ex_target_i      : ex_pc_i + PC_STEP;
    assign w_pred_pc   = ex_pred_taken_i ? ex_pred_target_i : ex_pc_i + PC_STEP;
    assign w_mispred   = w_upd & (w_actual_pc != w_pred_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                if (ex_taken_i) begin
                    r_ctr[w_ex_idx]    <= ctr_inc(r_ctr[w_ex_idx]);
                    r_target[w_ex_idx] <= ex_target_i;
                end else begin
                    r_ctr[w_ex_idx]    <= ctr_dec(r_ctr[w_ex_idx]);
                end
            end else if (ex_taken_i) begin
                // Taken miss claims the slot, evicting any alias; start weakly taken
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target_i;
                r_ctr[w_ex_idx]    <= 2'b10;
            end
        end
    end

    // P1: registered flush/redirect and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_p1       <= 1'b0;
            r_redirect_pc_p1 <= '0;
            r_br_cnt         <= '0;
            r_mispred_cnt    <= '0;
        end else begin
            r_flush_p1 <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc_p1 <= w_actual_pc;
                r_mispred_cnt    <= r_mispred_cnt + 32'd1;
            end
            if (w_upd) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
        end
    end

    assign flush_o       = r_flush_p1;
    assign redirect_pc_o = r_redirect_pc_p1;
    assign br_cnt_o      = r_br_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule
